timer_tick_gen: RTL

Parametrised successor to the fixed 12 MHz timing-pulse generator. It derives aligned single-cycle base ticks (1 us, 1 ms, 100 ms, 1 s) from refclk for any integer-MHz clock. It also provides NUM_CH independent programmable timer channels, each with its own period, base select and one-shot/periodic mode. It sits at chip top and feeds flashers, debouncers and UART timeouts, so those blocks do not need their own counters.

---
 rtl/timer_pkg.sv | 21 ++
 rtl/timer_channel.sv | 96 +++++++++
 rtl/timer_tick_gen.sv | 104 ++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// timer_pkg: shared constants and types for timer_tick_gen.
//   BASE_*      : channel base-select encodings (refclk / 1 us / 1 ms / 100 ms)
//   *_PER_*     : divide ratios of the base tick chain
//   chState_t   : channel FSM state
package timer_pkg;

    localparam logic [1:0] BASE_CLK = 2'd0;
    localparam logic [1:0] BASE_US  = 2'd1;
    localparam logic [1:0] BASE_MS  = 2'd2;
    localparam logic [1:0] BASE_HMS = 2'd3;

    localparam int US_PER_MS  = 1000;
    localparam int MS_PER_HMS = 100;
    localparam int HMS_PER_S  = 10;

    typedef enum logic {
        CH_IDLE = 1'b0,
        CH_RUN  = 1'b1
    } chState_t;

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one programmable down-counting timer.
//   refclk, rst              : clock, async active-high reset
//   clkEv/usEv/msEv/hmsEv    : base events (one-cycle pulses)
//   start, stop              : restart / abort pulses (stop wins)
//   periodic                 : auto-reload when latched at start
//   baseSel                  : live base select (BASE_* encoding)
//   period                   : reload value in base events, 0 = start ignored
//   busy                     : channel is counting
//   tick                     : registered one-cycle expiry pulse
module timer_channel
    import timer_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             clkEv,
    input  logic             usEv,
    input  logic             msEv,
    input  logic             hmsEv,
    input  logic             start,
    input  logic             stop,
    input  logic             periodic,
    input  logic [1:0]       baseSel,
    input  logic [CNT_W-1:0] period,
    output logic             busy,
    output logic             tick
);

    chState_t         state, stateNext;
    logic [CNT_W-1:0] cnt, cntNext;
    logic [CNT_W-1:0] perLat, perLatNext;
    logic             modeLat, modeLatNext;
    logic             tickNext;
    logic             baseEv;

    always_comb begin
        baseEv = clkEv;
        case (baseSel)
            BASE_CLK: baseEv = clkEv;
            BASE_US:  baseEv = usEv;
            BASE_MS:  baseEv = msEv;
            BASE_HMS: baseEv = hmsEv;
            default:  baseEv = clkEv;
        endcase
    end

    // Priority: stop > start (non-zero period) > base event.
    always_comb begin
        stateNext   = state;
        cntNext     = cnt;
        perLatNext  = perLat;
        modeLatNext = modeLat;
        tickNext    = 1'b0;
        if (stop) begin
            stateNext = CH_IDLE;
            cntNext   = '0;
        end else if (start && (period != '0)) begin
            stateNext   = CH_RUN;
            cntNext     = period;
            perLatNext  = period;
            modeLatNext = periodic;
        end else if ((state == CH_RUN) && baseEv) begin
            if (cnt == CNT_W'(1)) begin
                tickNext = 1'b1;
                if (modeLat) begin
                    cntNext = perLat;
                end else begin
                    stateNext = CH_IDLE;
                    cntNext   = '0;
                end
            end else begin
                cntNext = cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state   <= CH_IDLE;
            cnt     <= '0;
            perLat  <= '0;
            modeLat <= 1'b0;
            tick    <= 1'b0;
        end else begin
            state   <= stateNext;
            cnt     <= cntNext;
            perLat  <= perLatNext;
            modeLat <= modeLatNext;
            tick    <= tickNext;
        end
    end

    assign busy = (state == CH_RUN);

endmodule

// File: rtl/timer_tick_gen.sv
// timer_tick_gen: aligned base ticks (1 us / 1 ms / 100 ms / 1 s) from an
// integer-MHz refclk, plus NUM_CH programmable timer channels.
//   refclk, rst                     : clock, async active-high reset
//   us/ms/hundred_ms/sec_tick       : registered one-cycle base pulses
//   ch_start/ch_stop/ch_periodic    : per-channel control, one bit each
//   ch_base                         : 2 bits per channel, BASE_* encoding
//   ch_period                       : CNT_W bits per channel
//   ch_busy, ch_tick                : per-channel status / expiry pulse
module timer_tick_gen
    import timer_pkg::*;
#(
    parameter int INPUT_CLK_FREQ = 12_000_000,
    parameter int NUM_CH         = 4,
    parameter int CNT_W          = 16
) (
    input  logic                    refclk,
    input  logic                    rst,
    output logic                    us_tick,
    output logic                    ms_tick,
    output logic                    hundred_ms_tick,
    output logic                    sec_tick,
    input  logic [NUM_CH-1:0]       ch_start,
    input  logic [NUM_CH-1:0]       ch_stop,
    input  logic [NUM_CH-1:0]       ch_periodic,
    input  logic [2*NUM_CH-1:0]     ch_base,
    input  logic [CNT_W*NUM_CH-1:0] ch_period,
    output logic [NUM_CH-1:0]       ch_busy,
    output logic [NUM_CH-1:0]       ch_tick
);

    localparam int P  = INPUT_CLK_FREQ / 1_000_000;
    localparam int PW = $clog2(P);
    localparam int UW = $clog2(US_PER_MS);
    localparam int MW = $clog2(MS_PER_HMS);
    localparam int HW = $clog2(HMS_PER_S);

    localparam logic [PW-1:0] PRESC_LAST = PW'(P - 1);
    localparam logic [UW-1:0] US_LAST    = UW'(US_PER_MS - 1);
    localparam logic [MW-1:0] MS_LAST    = MW'(MS_PER_HMS - 1);
    localparam logic [HW-1:0] HMS_LAST   = HW'(HMS_PER_S - 1);

    if ((INPUT_CLK_FREQ % 1_000_000 != 0) || (INPUT_CLK_FREQ < 2_000_000)) begin : gBadFreq
        $error("timer_tick_gen: INPUT_CLK_FREQ must be a multiple of 1 MHz and >= 2 MHz");
    end
    if ((NUM_CH < 1) || (NUM_CH > 16)) begin : gBadCh
        $error("timer_tick_gen: NUM_CH must be 1..16");
    end

    logic [PW-1:0] presc;
    logic [UW-1:0] usCnt;
    logic [MW-1:0] msCnt;
    logic [HW-1:0] hmsCnt;
    logic          usEv, msEv, hmsEv, sEv;

    // Every stage's event is decoded from the same prescaler wrap, so all
    // four ticks are registered on one edge and coincide without skew.
    assign usEv  = (presc == PRESC_LAST);
    assign msEv  = usEv  && (usCnt  == US_LAST);
    assign hmsEv = msEv  && (msCnt  == MS_LAST);
    assign sEv   = hmsEv && (hmsCnt == HMS_LAST);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            presc           <= '0;
            usCnt           <= '0;
            msCnt           <= '0;
            hmsCnt          <= '0;
            us_tick         <= 1'b0;
            ms_tick         <= 1'b0;
            hundred_ms_tick <= 1'b0;
            sec_tick        <= 1'b0;
        end else begin
            presc  <= usEv  ? '0 : presc + PW'(1);
            if (usEv)  usCnt  <= msEv  ? '0 : usCnt  + UW'(1);
            if (msEv)  msCnt  <= hmsEv ? '0 : msCnt  + MW'(1);
            if (hmsEv) hmsCnt <= sEv   ? '0 : hmsCnt + HW'(1);
            us_tick         <= usEv;
            ms_tick         <= msEv;
            hundred_ms_tick <= hmsEv;
            sec_tick        <= sEv;
        end
    end

    // Channels count the registered ticks, so a channel expiry lands one
    // cycle after the base tick it counted.
    for (genvar i = 0; i < NUM_CH; i++) begin : gCh
        timer_channel #(.CNT_W(CNT_W)) uCh (
            .refclk   (refclk),
            .rst      (rst),
            .clkEv    (1'b1),
            .usEv     (us_tick),
            .msEv     (ms_tick),
            .hmsEv    (hundred_ms_tick),
            .start    (ch_start[i]),
            .stop     (ch_stop[i]),
            .periodic (ch_periodic[i]),
            .baseSel  (ch_base[2*i +: 2]),
            .period   (ch_period[CNT_W*i +: CNT_W]),
            .busy     (ch_busy[i]),
            .tick     (ch_tick[i])
        );
    end

endmodule
